// File: rtl/rr_arb_mux_pkg.sv
// Shared encodings and helpers for the round-robin arbiter/mux.
package rr_arb_mux_pkg;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_mux_grant.sv
// Rotating priority encoder: first request at or after ptr wins.
module rr_grant #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any_req
);

  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |req;
    for (int off = 0; off < N; off++) begin
      if (!found && req[(int'(ptr) + off) % N]) begin
        found                      = 1'b1;
        gnt[(int'(ptr) + off) % N] = 1'b1;
        idx                        = SEL_W'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbiter feeding a one-entry registered valid/ready output.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 32,
  parameter int RR_MODE = 1,
  localparam int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_use;
  logic [SEL_W-1:0]  gidx;
  logic [NUM_IN-1:0] gnt;
  logic              any_req;
  logic              load_en;
  logic              xfer;

  assign ptr_use = (RR_MODE == ARB_RR) ? ptr : '0;

  rr_grant #(
    .N     (NUM_IN),
    .SEL_W (SEL_W)
  ) u_grant (
    .req     (in_valid),
    .ptr     (ptr_use),
    .gnt     (gnt),
    .idx     (gidx),
    .any_req (any_req)
  );

  // reset blocks acceptance so nothing is lost to a discarded load
  assign load_en  = !reset && (out_valid == EMPTY || out_ready);
  assign in_ready = load_en ? gnt : '0;
  assign xfer     = load_en && any_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= EMPTY;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= FULL;
      out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
      out_src   <= gidx;
      if (RR_MODE == ARB_RR)
        ptr <= (int'(gidx) == NUM_IN-1) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid <= EMPTY;
    end
  end

endmodule
